// File: rtl/maple_pkg.sv
// Shared definitions for the Maple bus transmit path: one-hot frame states,
// start-pattern geometry and the idle levels of the two Maple lines.
package maple_pkg;

    typedef enum logic [8:0] {
        StIdle     = 9'b000000001,
        StLead     = 9'b000000010,
        StPat      = 9'b000000100,
        StTail     = 9'b000001000,
        StPayload  = 9'b000010000,
        StCrc      = 9'b000100000,
        StWaitDone = 9'b001000000,
        StTurn     = 9'b010000000,
        StDone     = 9'b100000000
    } maple_state_e;

    localparam int unsigned PatHalfPhases = 8;

    localparam logic SdckaIdle = 1'b1;
    localparam logic SdckbIdle = 1'b1;

endpackage

// File: rtl/maple_start_pattern.sv
// Maple start pattern generator: LEAD (both lines high), PAT (SDCKA low, SDCKB toggling
// over eight half-phases) and TAIL, each half-phase HALF cycles long.
module maple_start_pattern
    import maple_pkg::*;
#(
    parameter int unsigned HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic go_i,
    input  logic abort_i,
    output logic sdcka_o,
    output logic sdckb_o,
    output logic done_o
);

    maple_state_e state_q, state_d;
    logic [7:0]   half_q, half_d;
    logic [2:0]   phase_q, phase_d;
    logic         half_end;

    assign half_end = (half_q == 8'(HALF - 1));

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        phase_d = phase_q;
        sdcka_o = SdckaIdle;
        sdckb_o = SdckbIdle;
        done_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go_i) begin
                    state_d = StLead;
                    half_d  = '0;
                end
            end
            StLead: begin
                if (half_end) begin
                    state_d = StPat;
                    half_d  = '0;
                    phase_d = '0;
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            StPat: begin
                sdcka_o = 1'b0;
                sdckb_o = phase_q[0];
                if (half_end) begin
                    half_d  = '0;
                    phase_d = phase_q + 3'd1;
                    if (phase_q == 3'(PatHalfPhases - 1)) begin
                        state_d = StTail;
                    end
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            StTail: begin
                if (half_end) begin
                    state_d = StIdle;
                    half_d  = '0;
                    done_o  = 1'b1;
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort_i) begin
            state_d = StIdle;
            half_d  = '0;
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            half_q  <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/maple_tx_controller.sv
// Maple bus transmit frame sequencer: start pattern, AXIS payload to the encoder,
// turnaround and response timeout. Define MAPLE_TX_CRC_EN to append an XOR checksum byte.
module maple_tx_controller
    import maple_pkg::*;
#(
    parameter int unsigned HALF         = 2,
    parameter int unsigned RESP_TIMEOUT = 65535,
    parameter int unsigned CNT_W        = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             S_AXIS_TVALID,
    output logic             S_AXIS_TREADY,
    input  logic             S_AXIS_TLAST,
    input  logic [7:0]       S_AXIS_TDATA,
    output logic             M_AXIS_TVALID,
    input  logic             M_AXIS_TREADY,
    output logic             M_AXIS_TLAST,
    output logic [7:0]       M_AXIS_TDATA,
    output logic             enc_enable,
    input  logic             enc_done,
    output logic             pat_sel,
    output logic             sdcka,
    output logic             sdckb,
    output logic             bus_oe,
    output logic             rx_enable,
    input  logic             rx_frame_done,
    output logic             busy,
    output logic             tx_done,
    output logic             timeout,
    output logic [CNT_W-1:0] tx_bytes
);

    localparam int unsigned       TimerW    = 20;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(RESP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CntMax    = '1;

    maple_state_e      state_q, state_d;
    logic              bus_oe_q, bus_oe_d;
    logic              pat_sel_q, pat_sel_d;
    logic              enc_enable_q, enc_enable_d;
    logic              rx_enable_q, rx_enable_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  tx_bytes_q, tx_bytes_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]  tx_bytes_inc;
    logic              pat_go, pat_done, s_hs;
`ifdef MAPLE_TX_CRC_EN
    logic [7:0]        csum_q, csum_d;
    logic              m_hs;
`endif

    assign pat_go       = (state_q == StIdle) && start && !abort;
    assign tx_bytes_inc = (tx_bytes_q == CntMax) ? tx_bytes_q : tx_bytes_q + 1'b1;

    maple_start_pattern #(
        .HALF(HALF)
    ) u_start_pattern (
        .clk    (clk),
        .reset  (reset),
        .go_i   (pat_go),
        .abort_i(abort),
        .sdcka_o(sdcka),
        .sdckb_o(sdckb),
        .done_o (pat_done)
    );

    // Abort also blanks the handshakes in its own cycle so nothing is half-accepted.
    always_comb begin
        S_AXIS_TREADY = 1'b0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TDATA  = 8'h00;
        if (state_q == StPayload) begin
            M_AXIS_TVALID = S_AXIS_TVALID;
            S_AXIS_TREADY = M_AXIS_TREADY;
            M_AXIS_TDATA  = S_AXIS_TDATA;
`ifdef MAPLE_TX_CRC_EN
            M_AXIS_TLAST  = 1'b0;
`else
            M_AXIS_TLAST  = S_AXIS_TLAST;
`endif
        end
`ifdef MAPLE_TX_CRC_EN
        if (state_q == StCrc) begin
            M_AXIS_TVALID = 1'b1;
            M_AXIS_TDATA  = csum_q;
            M_AXIS_TLAST  = 1'b1;
        end
`endif
        if (abort) begin
            S_AXIS_TREADY = 1'b0;
            M_AXIS_TVALID = 1'b0;
        end
    end

    assign s_hs = S_AXIS_TVALID && S_AXIS_TREADY;
`ifdef MAPLE_TX_CRC_EN
    assign m_hs = M_AXIS_TVALID && M_AXIS_TREADY;
`endif

    // StLead stands for the whole start pattern; its LEAD/PAT/TAIL sub-phases live in
    // maple_start_pattern and pat_done marks the last TAIL cycle.
    always_comb begin
        state_d      = state_q;
        bus_oe_d     = bus_oe_q;
        pat_sel_d    = pat_sel_q;
        enc_enable_d = 1'b0;
        rx_enable_d  = rx_enable_q;
        timeout_d    = timeout_q;
        tx_bytes_d   = tx_bytes_q;
        timer_d      = timer_q;
`ifdef MAPLE_TX_CRC_EN
        csum_d       = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLead;
                    bus_oe_d   = 1'b1;
                    pat_sel_d  = 1'b1;
                    timeout_d  = 1'b0;
                    tx_bytes_d = '0;
`ifdef MAPLE_TX_CRC_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            StLead: begin
                if (pat_done) begin
                    state_d      = StPayload;
                    pat_sel_d    = 1'b0;
                    enc_enable_d = 1'b1;
                end
            end
            StPayload: begin
                if (s_hs) begin
                    tx_bytes_d = tx_bytes_inc;
`ifdef MAPLE_TX_CRC_EN
                    csum_d     = csum_q ^ S_AXIS_TDATA;
                    if (S_AXIS_TLAST) state_d = StCrc;
`else
                    if (S_AXIS_TLAST) state_d = StWaitDone;
`endif
                end
            end
`ifdef MAPLE_TX_CRC_EN
            StCrc: begin
                if (m_hs) begin
                    tx_bytes_d = tx_bytes_inc;
                    state_d    = StWaitDone;
                end
            end
`endif
            StWaitDone: begin
                if (enc_done) begin
                    bus_oe_d    = 1'b0;
                    rx_enable_d = 1'b1;
                    timer_d     = '0;
                    state_d     = StTurn;
                end
            end
            StTurn: begin
                timer_d = timer_q + 1'b1;
                if (rx_frame_done) begin
                    state_d     = StDone;
                    rx_enable_d = 1'b0;
                end else if (timer_q == TimerLast) begin
                    state_d     = StDone;
                    rx_enable_d = 1'b0;
                    timeout_d   = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d      = StIdle;
            bus_oe_d     = 1'b0;
            pat_sel_d    = 1'b0;
            rx_enable_d  = 1'b0;
            enc_enable_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            bus_oe_q     <= 1'b0;
            pat_sel_q    <= 1'b0;
            enc_enable_q <= 1'b0;
            rx_enable_q  <= 1'b0;
            timeout_q    <= 1'b0;
            tx_bytes_q   <= '0;
            timer_q      <= '0;
`ifdef MAPLE_TX_CRC_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            bus_oe_q     <= bus_oe_d;
            pat_sel_q    <= pat_sel_d;
            enc_enable_q <= enc_enable_d;
            rx_enable_q  <= rx_enable_d;
            timeout_q    <= timeout_d;
            tx_bytes_q   <= tx_bytes_d;
            timer_q      <= timer_d;
`ifdef MAPLE_TX_CRC_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign bus_oe     = bus_oe_q;
    assign pat_sel    = pat_sel_q;
    assign enc_enable = enc_enable_q;
    assign rx_enable  = rx_enable_q;
    assign timeout    = timeout_q;
    assign tx_bytes   = tx_bytes_q;
    assign busy       = (state_q != StIdle);
    assign tx_done    = (state_q == StDone);

endmodule
